// File: rtl/fetch_stage.sv
// fetch_stage: instruction fetch between PC and decode.
// Issues one imem request at a time for the current PC, buffers returned
// words together with their PCs in a DEPTH-entry queue, and drops all
// buffered and in-flight work on flush.
// Optional: define FETCH_ALIGN_CHECK_EN to enable the sticky misaligned-fetch
// flag (fetch_err); otherwise fetch_err is tied to 0.
module fetch_stage #(
  parameter int DEPTH = 2,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] pc,
  output logic        pc_adv,
  input  logic        flush,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_data,
  output logic [31:0] inst_pc,
  output logic        fetch_err
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DROP} state_t;

  localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

  state_t                  state_q, state_d;
  logic [PTR_W-1:0]        wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]        rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]          count_q, count_d;
  logic [DEPTH-1:0][31:0]  data_q, data_d;
  logic [DEPTH-1:0][31:0]  ipc_q, ipc_d;
  logic [31:0]             req_pc_q, req_pc_d;
  logic                    hs, push, pop;

  // Request side is decoded straight from the state register
  assign imem_req_valid = (state_q == REQ);
  assign imem_req_addr  = imem_req_valid ? {pc[31:2], 2'b00} : 32'h0;
  assign hs             = imem_req_valid & imem_req_ready;
  // A handshake coincident with flush is accepted but must not advance PC
  assign pc_adv         = hs & ~flush;

  // Queue head goes to decode directly from storage; reads 0 when empty
  assign inst_valid = (count_q != '0);
  assign inst_data  = inst_valid ? data_q[rd_ptr_q] : 32'h0;
  assign inst_pc    = inst_valid ? ipc_q[rd_ptr_q]  : 32'h0;

  assign push = (state_q == WAIT) & imem_rsp_valid & ~flush;
  assign pop  = inst_valid & inst_ready;

  // Queue bookkeeping: flush clears everything, else push/pop update pointers
  always_comb begin
    count_d  = count_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    data_d   = data_q;
    ipc_d    = ipc_q;
    if (flush) begin
      count_d  = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) begin
        data_d[wr_ptr_q] = imem_rsp_data;
        ipc_d[wr_ptr_q]  = req_pc_q;
        wr_ptr_d         = wr_ptr_q + PTR_W'(1);
      end
      if (pop) rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + (PTR_W+1)'(1);
        2'b01:   count_d = count_q - (PTR_W+1)'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // Fetch FSM next state; flush has priority over every other transition
  always_comb begin
    state_d  = state_q;
    req_pc_d = hs ? pc : req_pc_q;
    unique case (state_q)
      IDLE: if (!flush && count_q < FULL) state_d = REQ;
      REQ: begin
        if (hs)         state_d = flush ? DROP : WAIT;
        else if (flush) state_d = IDLE;
      end
      WAIT: begin
        if (flush)               state_d = imem_rsp_valid ? IDLE : DROP;
        else if (imem_rsp_valid) state_d = (count_d < FULL) ? REQ : IDLE;
      end
      DROP: if (imem_rsp_valid) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // State and queue registers, synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      count_q  <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      data_q   <= '0;
      ipc_q    <= '0;
      req_pc_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      data_q   <= data_d;
      ipc_q    <= ipc_d;
      req_pc_q <= req_pc_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic err_q, err_d;

  // Sticky flag: set by any accepted request whose PC is not word aligned
  always_comb begin
    err_d = err_q | (hs & (pc[1:0] != 2'b00));
  end

  // Error flag register, cleared only by reset
  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end

  assign fetch_err = err_q;
`else
  assign fetch_err = 1'b0;
`endif

endmodule
